// File: rtl/pid_state_vec_if.sv
// Bus bundle between the upstream sampler, the state-vector builder and the
// downstream dot-product stage.
interface pid_state_vec_if #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 18
);
  logic                        sample_valid;
  logic signed [IN_WIDTH-1:0]  position;
  logic signed [IN_WIDTH-1:0]  setpoint;
  logic                        integ_clear;
  logic                        dp_done;
  logic signed [OUT_WIDTH-1:0] err;
  logic signed [OUT_WIDTH-1:0] derr;
  logic signed [OUT_WIDTH-1:0] ierr;
  logic                        vec_valid;
  logic                        busy;
  logic                        overrun;
  logic                        timeout_err;
  logic [7:0]                  drop_count;

  // Upstream/downstream side: drives samples and completion, observes the vector.
  modport master (
    output sample_valid, position, setpoint, integ_clear, dp_done,
    input  err, derr, ierr, vec_valid, busy, overrun, timeout_err, drop_count
  );

  // State-vector builder side.
  modport slave (
    input  sample_valid, position, setpoint, integ_clear, dp_done,
    output err, derr, ierr, vec_valid, busy, overrun, timeout_err, drop_count
  );
endinterface

// File: rtl/pid_state_vec.sv
// Builds the PID state vector (e, de, i) from one position/setpoint sample,
// presents it to a downstream dot-product stage and holds it until the next
// sample is computed. Samples arriving while busy are dropped and counted.
module pid_state_vec #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 18,
  parameter int INT_LIMIT = 1000,
  parameter int TIMEOUT   = 16
) (
  input  logic           clock,
  input  logic           reset,
  pid_state_vec_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [OUT_WIDTH:0] LIM_P = (OUT_WIDTH + 1)'(INT_LIMIT);
  localparam logic signed [OUT_WIDTH:0] LIM_N = -LIM_P;

  typedef enum logic [1:0] {IDLE, CALC, WAIT} state_t;

  state_t                      state_q;
  logic signed [IN_WIDTH-1:0]  pos_q, sp_q;
  logic signed [IN_WIDTH:0]    eprev_q;
  logic                        first_q;
  logic signed [OUT_WIDTH-1:0] integ_q, err_q, derr_q, ierr_q;
  logic                        vec_valid_q, busy_q, overrun_q, timeout_q;
  logic [7:0]                  drop_q;
  logic [CW-1:0]               wcnt_q;

  logic signed [IN_WIDTH:0]    e_d;
  logic signed [IN_WIDTH+1:0]  de_raw;
  logic signed [OUT_WIDTH-1:0] ibase;
  logic signed [OUT_WIDTH:0]   isum;
  logic signed [OUT_WIDTH-1:0] err_d, derr_d, ierr_d;
  logic                        first_d;

  // Symmetric integral clamp on the one-bit-wider accumulator sum.
  function automatic logic signed [OUT_WIDTH-1:0] clamp_int(input logic signed [OUT_WIDTH:0] v);
    if (v > LIM_P)      return OUT_WIDTH'(LIM_P);
    else if (v < LIM_N) return OUT_WIDTH'(LIM_N);
    else                return OUT_WIDTH'(v);
  endfunction

  // Next state-vector values; a coincident integ_clear acts before the update.
  always_comb begin
    e_d     = {sp_q[IN_WIDTH-1], sp_q} - {pos_q[IN_WIDTH-1], pos_q};
    de_raw  = {e_d[IN_WIDTH], e_d} - {eprev_q[IN_WIDTH], eprev_q};
    first_d = first_q | bus.integ_clear;
    ibase   = bus.integ_clear ? '0 : integ_q;
    isum    = (OUT_WIDTH + 1)'(ibase) + (OUT_WIDTH + 1)'(e_d);
    err_d   = OUT_WIDTH'(e_d);
    derr_d  = first_d ? '0 : OUT_WIDTH'(de_raw);
    ierr_d  = clamp_int(isum);
  end

  // Control FSM plus state-vector, integral, drop counter and WAIT timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      sp_q        <= '0;
      eprev_q     <= '0;
      first_q     <= 1'b1;
      integ_q     <= '0;
      err_q       <= '0;
      derr_q      <= '0;
      ierr_q      <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      drop_q      <= '0;
      wcnt_q      <= '0;
    end else begin
      vec_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;

      // Clear outside CALC; inside CALC the update below already folds it in.
      if (bus.integ_clear) begin
        integ_q <= '0;
        first_q <= 1'b1;
      end

      if (bus.sample_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end

      case (state_q)
        IDLE: begin
          if (bus.sample_valid) begin
            pos_q   <= bus.position;
            sp_q    <= bus.setpoint;
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          err_q       <= err_d;
          derr_q      <= derr_d;
          ierr_q      <= ierr_d;
          integ_q     <= ierr_d;
          eprev_q     <= e_d;
          first_q     <= 1'b0;
          vec_valid_q <= 1'b1;
          wcnt_q      <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // Completion wins over a timeout expiring in the same cycle.
          if (bus.dp_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.err         = err_q;
  assign bus.derr        = derr_q;
  assign bus.ierr        = ierr_q;
  assign bus.vec_valid   = vec_valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;
  assign bus.drop_count  = drop_q;

endmodule
